eth_tx_frame_arbiter: RTL and testbench
=======================================

# eth_tx_frame_arbiter

Frame-atomic AXI-Stream arbiter that shares the single 8-bit Ethernet TX path (`tx_axis_*`) between the ADC packetizer, the RX address-swap loopback and the pattern generator. It sits between those three frame sources and the MAC TX interface on the `axi_tclk` domain. It grants whole frames round-robin, with optional strict priority for the ADC source. It enforces a maximum frame length and an inter-frame gap.

## Interface
- `NUM_SRC`, 3, number of requesters; index 0 = ADC, 1 = loopback, 2 = pattern gen.
- `DATA_WIDTH`, 8, tdata width per source.
- `MAX_FRAME_LEN`, 16'd1522, maximum beats per granted frame.
- `GAP_CYCLES`, 12, idle cycles inserted after every frame (minimum 1).
- `PRIO_EN`, 1'b1, when 1 source 0 wins every arbitration it requests.

Ports:
- `axi_tclk` in 1 — sole clock.
- `axi_tresetn` in 1 — asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `src_enable` in NUM_SRC — per-source enable, sampled only at arbitration.
- `s_axis_tdata` in NUM_SRC*DATA_WIDTH — source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid`, `s_axis_tlast` in NUM_SRC — source handshake.
- `s_axis_tready` out NUM_SRC — at most one bit high at any time.
- `m_axis_tdata` out DATA_WIDTH; `m_axis_tvalid`, `m_axis_tlast` out 1; `m_axis_tready` in 1 — output to the TX path.
- `grant_id` out clog2(NUM_SRC) — source currently or last granted.
- `busy` out 1 — high in PASS/DRAIN.
- `overlong_pulse` out 1 — one-cycle pulse when a frame is truncated.
- `frame_count` out 16 — frames completed on master, wraps 0xFFFF→0.

## Operation
- States: IDLE, PASS, DRAIN, GAP.
- IDLE: `req = s_axis_tvalid & src_enable`.
  - If `PRIO_EN` and `req[0]`, pick 0.
  - Otherwise pick the first requester searching from `last_grant+1` cyclically.
  - Register `grant_id`, clear `beat_cnt`, go to PASS.
  - No request: stay in IDLE.
- PASS: combinational pass-through of the granted source.
  - `m_axis_tvalid = s_axis_tvalid[g]`, `m_axis_tdata = s_axis_tdata[g]`, `s_axis_tready[g] = m_axis_tready`.
  - `m_axis_tlast = s_axis_tlast[g] | (beat_cnt == MAX_FRAME_LEN-1)`.
  - `beat_cnt` increments on each master handshake.
  - Handshake with source tlast: `frame_count++`, go to GAP.
  - Handshake on beat MAX_FRAME_LEN without source tlast: forced tlast goes out, pulse `overlong_pulse`, `frame_count++`, go to DRAIN.
- DRAIN: `s_axis_tready[g] = 1`, `m_axis_tvalid = 0`. Discard source beats until source tlast is accepted, then go to GAP.
- GAP: all treadies 0, master idle, count GAP_CYCLES, then go to IDLE.
- `last_grant` updates at grant time.
- Outside PASS, `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` are 0.
- A source disabled mid-frame keeps its grant until its frame ends.
- Valid dropping mid-frame keeps the grant; there is no timeout.

## Timing
- Reset values: `m_axis_tvalid`/`tlast`/`tdata` = 0, `s_axis_tready` = 0, `grant_id` = 0, `busy` = 0, `overlong_pulse` = 0, `frame_count` = 0, state IDLE.
- `last_grant` resets to NUM_SRC-1, so source 0 is preferred first.
- Arbitration latency: request seen in IDLE at cycle N → PASS at N+1; first beat can transfer at N+1.
- Data path in PASS: zero latency, with no register stage.
- Frame-to-frame spacing:
  - Source tlast accepted at cycle T → GAP for cycles T+1..T+GAP_CYCLES.
  - IDLE at T+GAP_CYCLES+1.
  - Next grant visible at T+GAP_CYCLES+2.
- `overlong_pulse` is high the cycle after the truncating handshake.
- Simultaneous requests in IDLE are resolved in a single cycle; no request is lost, since tvalid is held by the source.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). Partial source frames are not recovered; the next arbitration treats the remainder as a new frame.

## Structure
- Shared package `eth_tx_pkg`:
  - state enum
  - source index constants `SRC_ADC = 0`, `SRC_LOOP = 1`, `SRC_PATGEN = 2`
  - `ETH_MAX_FRAME = 1522`, `ETH_IFG_BYTES = 12`
- One natural sub-module, `rr_priority_picker`: combinational round-robin/priority select from `req`, `last_grant` and `PRIO_EN`, producing a one-hot plus index output.

## Test plan
- All three sources each present one 64-byte frame simultaneously, `PRIO_EN` = 0, tready = 1 → order is 0, 1, 2; gaps of 12 idle cycles; `frame_count` = 3.
- `PRIO_EN` = 1, source 0 streams continuously, source 2 waits → source 0 wins every arbitration. With `PRIO_EN` = 0, order is 0, 2, 0, 2.
- `MAX_FRAME_LEN` = 500, source 1 sends 700 beats → master gets 500 beats with tlast on beat 500; `overlong_pulse` fires once; 200 beats drained with `m_axis_tvalid` = 0.
- m_tready pattern 1,1,1,0,1,1,0,1 during a 64-byte frame → all 64 bytes out in order; `s_axis_tready[g]` mirrors m_tready.
- `src_enable[0]` cleared mid-frame → frame completes; source 0 is then never granted while disabled.
- `axi_tresetn` asserted at beat 20 → all outputs 0 within the same cycle, `frame_count` = 0; after release, the first grant goes to source 0.

Source files
------------

// File: rtl/eth_tx_frame_arbiter_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
// Covers the arbiter FSM states, the source index map and the Ethernet framing limits.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  localparam int SRC_ADC    = 0;
  localparam int SRC_LOOP   = 1;
  localparam int SRC_PATGEN = 2;

  localparam int ETH_MAX_FRAME = 1522;
  localparam int ETH_IFG_BYTES = 12;

  // Index width that stays at least one bit even for a single source.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// Bundles the per-source AXI-Stream inputs and the single master output of the arbiter.
// slave = arbiter side (sinks sources, drives TX); master = the sources plus the TX path.
interface eth_tx_frame_arbiter_if #(
  parameter int NUM_SRC    = 3,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]            s_axis_tvalid;
  logic [NUM_SRC-1:0]            s_axis_tlast;
  logic [NUM_SRC-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tlast;
  logic                          m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/eth_tx_frame_arbiter_picker.sv
// Combinational round-robin pick with optional absolute priority for the ADC source.
// The search starts one past the last grant and wraps, so every requester is reached.
module rr_priority_picker
  import eth_tx_pkg::*;
#(
  parameter int  NUM_SRC = 3,
  parameter bit  PRIO_EN = 1'b1,
  localparam int GW      = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [GW-1:0]      i_last_grant,
  output logic [NUM_SRC-1:0] o_onehot,
  output logic [GW-1:0]      o_index,
  output logic               o_valid
);
  logic          w_found;
  logic [GW-1:0] w_cand;

  always_comb begin
    o_valid = |i_req;
    o_index = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = GW'((int'(i_last_grant) + k) % NUM_SRC);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_index = w_cand;
      end
    end
    if (PRIO_EN && i_req[SRC_ADC]) begin
      o_index = GW'(SRC_ADC);
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
    assign o_onehot[gi] = o_valid && (o_index == GW'(gi));
  end
endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic arbiter sharing one AXI-Stream TX path between several frame sources.
// Whole frames are granted; overlong frames are cut and their tail drained, then a gap follows.
module eth_tx_frame_arbiter
  import eth_tx_pkg::*;
#(
  parameter int          NUM_SRC       = 3,
  parameter int          DATA_WIDTH    = 8,
  parameter logic [15:0] MAX_FRAME_LEN = 16'(ETH_MAX_FRAME),
  parameter int          GAP_CYCLES    = ETH_IFG_BYTES,
  parameter bit          PRIO_EN       = 1'b1,
  localparam int         GW            = idx_width(NUM_SRC)
) (
  input  logic                  axi_tclk,
  input  logic                  axi_tresetn,
  input  logic [NUM_SRC-1:0]    src_enable,
  eth_tx_frame_arbiter_if.slave axis,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  overlong_pulse,
  output logic [15:0]           frame_count
);
  arb_state_t            r_state, w_state_next;
  logic [GW-1:0]         r_grant, w_grant_next;
  logic [GW-1:0]         r_last_grant, w_last_grant_next;
  logic [NUM_SRC-1:0]    r_grant_oh, w_grant_oh_next;
  logic [15:0]           r_beat_cnt, w_beat_cnt_next;
  logic [15:0]           r_gap_cnt, w_gap_cnt_next;
  logic [15:0]           r_frame_cnt, w_frame_cnt_next;
  logic                  r_overlong, w_overlong_next;

  logic [NUM_SRC-1:0]    w_req, w_pick_oh;
  logic [GW-1:0]         w_pick_idx;
  logic                  w_pick_valid;
  logic [DATA_WIDTH-1:0] w_src_tdata [NUM_SRC];
  logic [DATA_WIDTH-1:0] w_sel_tdata;
  logic                  w_sel_valid, w_sel_last, w_force_last;

  assign w_req = axis.s_axis_tvalid & src_enable;

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .PRIO_EN (PRIO_EN)
  ) u_picker (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_onehot     (w_pick_oh),
    .o_index      (w_pick_idx),
    .o_valid      (w_pick_valid)
  );

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_src_tdata[gi] = axis.s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // AND-OR mux on the registered one-hot keeps the zero-latency data path shallow.
  always_comb begin
    w_sel_tdata = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sel_tdata = w_sel_tdata | ({DATA_WIDTH{r_grant_oh[k]}} & w_src_tdata[k]);
    end
  end

  assign w_sel_valid  = |(axis.s_axis_tvalid & r_grant_oh);
  assign w_sel_last   = |(axis.s_axis_tlast & r_grant_oh);
  assign w_force_last = (r_beat_cnt == MAX_FRAME_LEN - 16'd1);

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_last_grant_next  = r_last_grant;
    w_grant_oh_next    = r_grant_oh;
    w_beat_cnt_next    = r_beat_cnt;
    w_gap_cnt_next     = r_gap_cnt;
    w_frame_cnt_next   = r_frame_cnt;
    w_overlong_next    = 1'b0;
    axis.s_axis_tready = '0;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_next      = w_pick_idx;
          w_last_grant_next = w_pick_idx;
          w_grant_oh_next   = w_pick_oh;
          w_beat_cnt_next   = '0;
          w_state_next      = ST_PASS;
        end
      end
      ST_PASS: begin
        axis.m_axis_tvalid = w_sel_valid;
        axis.m_axis_tdata  = w_sel_tdata;
        axis.m_axis_tlast  = w_sel_last | w_force_last;
        axis.s_axis_tready = r_grant_oh & {NUM_SRC{axis.m_axis_tready}};
        if (w_sel_valid && axis.m_axis_tready) begin
          w_beat_cnt_next = r_beat_cnt + 16'd1;
          if (w_sel_last) begin
            w_frame_cnt_next = r_frame_cnt + 16'd1;
            w_gap_cnt_next   = '0;
            w_state_next     = ST_GAP;
          end else if (w_force_last) begin
            w_frame_cnt_next = r_frame_cnt + 16'd1;
            w_overlong_next  = 1'b1;
            w_state_next     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        axis.s_axis_tready = r_grant_oh;
        if (w_sel_valid && w_sel_last) begin
          w_gap_cnt_next = '0;
          w_state_next   = ST_GAP;
        end
      end
      ST_GAP: begin
        w_gap_cnt_next = r_gap_cnt + 16'd1;
        if (r_gap_cnt == 16'(GAP_CYCLES - 1)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Last grant starts at the top index so the first search lands on source 0.
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_SRC - 1);
      r_grant_oh   <= '0;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_frame_cnt  <= '0;
      r_overlong   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_grant_oh   <= w_grant_oh_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_gap_cnt    <= w_gap_cnt_next;
      r_frame_cnt  <= w_frame_cnt_next;
      r_overlong   <= w_overlong_next;
    end
  end

  assign grant_id       = r_grant;
  assign busy           = (r_state == ST_PASS) || (r_state == ST_DRAIN);
  assign overlong_pulse = r_overlong;
  assign frame_count    = r_frame_cnt;
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: round-robin order, priority, truncation, backpressure,
// mid-frame disable and asynchronous reset, with a second instance built with ADC priority on.
module tb_eth_tx_frame_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] src_en;
  logic [1:0] grant_id, grant_id_p;
  logic       busy, busy_p, overlong, overlong_p;
  logic [15:0] frame_count, frame_count_p;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int len [3];
  int nfr [3];
  int idx [3];
  logic [7:0] mtr_pat;
  int mtr_ph;
  int ov_cnt, mirr_bad, oh_bad;
  logic [7:0] mon_data [$];
  logic       mon_last [$];
  logic [1:0] mon_gid  [$];
  int         mon_cyc  [$];
  logic [1:0] mon_gid_p [$];

  always #5 clk = ~clk;

  eth_tx_frame_arbiter_if #(.NUM_SRC(3), .DATA_WIDTH(8)) bus ();
  eth_tx_frame_arbiter_if #(.NUM_SRC(3), .DATA_WIDTH(8)) bus_p ();

  assign bus_p.s_axis_tdata  = bus.s_axis_tdata;
  assign bus_p.s_axis_tvalid = bus.s_axis_tvalid;
  assign bus_p.s_axis_tlast  = bus.s_axis_tlast;
  assign bus_p.m_axis_tready = bus.m_axis_tready;

  eth_tx_frame_arbiter #(
    .NUM_SRC(3), .DATA_WIDTH(8), .MAX_FRAME_LEN(16'd40), .GAP_CYCLES(12), .PRIO_EN(1'b0)
  ) dut (
    .axi_tclk(clk), .axi_tresetn(rst_n), .src_enable(src_en), .axis(bus.slave),
    .grant_id(grant_id), .busy(busy), .overlong_pulse(overlong), .frame_count(frame_count)
  );

  eth_tx_frame_arbiter #(
    .NUM_SRC(3), .DATA_WIDTH(8), .MAX_FRAME_LEN(16'd1522), .GAP_CYCLES(12), .PRIO_EN(1'b1)
  ) dut_p (
    .axi_tclk(clk), .axi_tresetn(rst_n), .src_enable(src_en), .axis(bus_p.slave),
    .grant_id(grant_id_p), .busy(busy_p), .overlong_pulse(overlong_p), .frame_count(frame_count_p)
  );

  function automatic logic [7:0] dat(input int s, input int i);
    return 8'(s * 64 + (i % 64));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int s, input int l, input int n);
    len[s] = l;
    nfr[s] = n;
    idx[s] = 0;
  endtask

  task automatic drive_srcs();
    for (int s = 0; s < 3; s++) begin
      bus.s_axis_tvalid[s]       = (nfr[s] > 0);
      bus.s_axis_tlast[s]        = (nfr[s] > 0) && (idx[s] == len[s] - 1);
      bus.s_axis_tdata[s*8 +: 8] = dat(s, idx[s]);
    end
    bus.m_axis_tready = mtr_pat[mtr_ph];
  endtask

  task automatic clear_mon();
    mon_data.delete(); mon_last.delete(); mon_gid.delete(); mon_cyc.delete(); mon_gid_p.delete();
    ov_cnt = 0; mirr_bad = 0; oh_bad = 0;
  endtask

  // Sample handshakes mid-cycle, then advance the source models after the edge.
  task automatic tick();
    logic [2:0] hs;
    @(negedge clk);
    hs = bus.s_axis_tvalid & bus.s_axis_tready;
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      mon_data.push_back(bus.m_axis_tdata);
      mon_last.push_back(bus.m_axis_tlast);
      mon_gid.push_back(grant_id);
      mon_cyc.push_back(cyc);
      $display("beat cyc=%0d src=%0d data=%02h last=%0b", cyc, grant_id, bus.m_axis_tdata, bus.m_axis_tlast);
    end
    if (bus_p.m_axis_tvalid && bus_p.m_axis_tready) mon_gid_p.push_back(grant_id_p);
    if (overlong) ov_cnt++;
    if (bus.m_axis_tvalid && (bus.s_axis_tready[grant_id] !== bus.m_axis_tready)) mirr_bad++;
    if ($countones(bus.s_axis_tready) > 1) oh_bad++;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      if (hs[s]) begin
        if (idx[s] == len[s] - 1) begin
          idx[s] = 0;
          nfr[s] = nfr[s] - 1;
        end else begin
          idx[s] = idx[s] + 1;
        end
      end
    end
    cyc++;
    mtr_ph = (mtr_ph + 1) % 8;
    drive_srcs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  initial begin
    int errs;
    int n0;
    logic [7:0] gp, gpp;
    rst_n   = 1'b0;
    src_en  = 3'b111;
    mtr_pat = 8'hFF;
    mtr_ph  = 0;
    for (int s = 0; s < 3; s++) set_src(s, 1, 0);
    drive_srcs();
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("rst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
    chk("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overlong", 32'(overlong), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);

    // Three simultaneous 16-beat frames, round-robin from source 0.
    for (int s = 0; s < 3; s++) set_src(s, 16, 1);
    drive_srcs();
    do_reset();
    repeat (100) tick();
    chk("A_beats", 32'(mon_data.size()), 32'd48);
    errs = 0;
    for (int k = 0; k < mon_data.size(); k++) begin
      if (mon_data[k] !== dat(k / 16, k % 16) || mon_last[k] !== (k % 16 == 15)) errs++;
    end
    chk("A_data", 32'(errs), 32'd0);
    chk("A_order", (mon_data.size() == 48) ? 32'({mon_gid[0], mon_gid[16], mon_gid[32]}) : 32'hFFFF, 32'b00_01_10);
    chk("A_burst", (mon_data.size() == 48) ? 32'(mon_cyc[15] - mon_cyc[0]) : 32'hFFFF, 32'd15);
    chk("A_gap01", (mon_data.size() == 48) ? 32'(mon_cyc[16] - mon_cyc[15]) : 32'hFFFF, 32'd14);
    chk("A_gap12", (mon_data.size() == 48) ? 32'(mon_cyc[32] - mon_cyc[31]) : 32'hFFFF, 32'd14);
    chk("A_frame_count", 32'(frame_count), 32'd3);
    chk("A_onehot", 32'(oh_bad), 32'd0);

    // Sources 0 and 2 request back to back: alternate without priority, 0 always with it.
    set_src(0, 1, 100); set_src(1, 1, 0); set_src(2, 1, 100);
    drive_srcs();
    do_reset();
    repeat (60) tick();
    gp  = (mon_gid.size() >= 4) ? {mon_gid[0], mon_gid[1], mon_gid[2], mon_gid[3]} : 8'hFF;
    gpp = (mon_gid_p.size() >= 4) ? {mon_gid_p[0], mon_gid_p[1], mon_gid_p[2], mon_gid_p[3]} : 8'hFF;
    chk("B_rr_order", 32'(gp), 32'b00_10_00_10);
    chk("B_prio_order", 32'(gpp), 32'd0);

    // Source 1 sends 60 beats against a 40-beat limit.
    set_src(0, 1, 0); set_src(1, 60, 1); set_src(2, 1, 0);
    drive_srcs();
    do_reset();
    repeat (90) tick();
    chk("C_beats", 32'(mon_data.size()), 32'd40);
    errs = 0;
    n0 = 0;
    for (int k = 0; k < mon_data.size(); k++) begin
      if (mon_data[k] !== dat(1, k)) errs++;
      if (mon_last[k]) n0++;
    end
    chk("C_data", 32'(errs), 32'd0);
    chk("C_last_on_40", (mon_data.size() == 40) ? 32'(mon_last[39]) : 32'hFFFF, 32'd1);
    chk("C_last_count", 32'(n0), 32'd1);
    chk("C_overlong_pulses", 32'(ov_cnt), 32'd1);
    chk("C_drained", 32'(nfr[1]), 32'd0);
    chk("C_frame_count", 32'(frame_count), 32'd1);
    chk("C_idle_busy", 32'(busy), 32'd0);

    // Backpressure pattern 1,1,1,0,1,1,0,1 on a 16-beat frame from source 2.
    set_src(1, 1, 0); set_src(2, 16, 1);
    mtr_pat = 8'b1011_0111;
    drive_srcs();
    do_reset();
    repeat (60) tick();
    chk("D_beats", 32'(mon_data.size()), 32'd16);
    errs = 0;
    for (int k = 0; k < mon_data.size(); k++) begin
      if (mon_data[k] !== dat(2, k) || mon_gid[k] !== 2'd2) errs++;
    end
    chk("D_data", 32'(errs), 32'd0);
    chk("D_tready_mirror", 32'(mirr_bad), 32'd0);
    chk("D_frame_count", 32'(frame_count), 32'd1);
    mtr_pat = 8'hFF;

    // Source 0 disabled mid-frame: its frame finishes, then only source 1 is served.
    set_src(0, 16, 2); set_src(1, 16, 1); set_src(2, 1, 0);
    drive_srcs();
    do_reset();
    repeat (6) tick();
    src_en = 3'b110;
    repeat (100) tick();
    n0 = 0;
    for (int k = 0; k < mon_gid.size(); k++) if (mon_gid[k] == 2'd0) n0++;
    chk("E_beats", 32'(mon_data.size()), 32'd32);
    chk("E_src0_beats", 32'(n0), 32'd16);
    chk("E_second_src", (mon_data.size() == 32) ? 32'(mon_gid[16]) : 32'hFFFF, 32'd1);
    chk("E_src0_pending", 32'(nfr[0]), 32'd1);
    chk("E_frame_count", 32'(frame_count), 32'd2);

    // Asynchronous reset after beat 20 of a source-0 frame.
    src_en = 3'b111;
    set_src(0, 30, 1); set_src(1, 10, 1);
    drive_srcs();
    clear_mon();
    for (int i = 0; i < 80 && mon_data.size() < 20; i++) tick();
    chk("F_pre_beats", 32'(mon_data.size()), 32'd20);
    #1 rst_n = 1'b0;
    #1;
    chk("F_rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("F_rst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
    chk("F_rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("F_rst_busy", 32'(busy), 32'd0);
    chk("F_rst_frame_count", 32'(frame_count), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 30 && mon_data.size() < 1; i++) tick();
    chk("F_post_grant", (mon_data.size() > 0) ? 32'(mon_gid[0]) : 32'hFFFF, 32'd0);
    chk("F_post_data", (mon_data.size() > 0) ? 32'(mon_data[0]) : 32'hFFFF, 32'(dat(0, 20)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
